router_ctrl: RTL and testbench
==============================

Name: router_ctrl

Overview:
- Control block of the 1x3 router: sequences packet reception into the three output FIFOs.
- Decodes the destination address from the header byte and drives write enables and state flags (lfd/ld/laf/full) to the register and FIFO blocks.
- Stalls on a full FIFO.
- Runs per-port read timeouts that soft-reset abandoned FIFOs.

Parameters:
TIMEOUT, 30, cycles vld_out[i] may stay high without read_enb[i] before soft_reset[i] pulses
CNT_W, 5, width of each timeout counter (must hold TIMEOUT-1)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
pkt_valid  in  1  source byte stream valid; low on the parity byte
data_in  in  2  header bits [1:0] = destination port (3 = invalid)
parity_done  in  1  register block: parity byte captured
low_pkt_valid  in  1  register block: pkt_valid fell while in LOAD_DATA/full
fifo_full  in  3  full flag per FIFO
fifo_empty  in  3  empty flag per FIFO
read_enb  in  3  per-port read strobe from the destination
write_enb  out  3  one-hot FIFO write strobe (latched address)
vld_out  out  3  per-port data available = ~fifo_empty
soft_reset  out  3  one-cycle per-port FIFO flush pulse
busy  out  1  source must hold current byte
detect_add  out  1  in DECODE_ADDRESS
lfd_state  out  1  in LOAD_FIRST_DATA (header write)
ld_state  out  1  in LOAD_DATA
laf_state  out  1  in LOAD_AFTER_FULL
full_state  out  1  in FIFO_FULL_STATE
write_enb_reg  out  1  register block may write toward FIFO
rst_int_reg  out  1  in CHECK_PARITY_ERROR

Behaviour:
- Reset: state=DECODE_ADDRESS, addr=0, all timeout counters 0, soft_reset=0. detect_add=1, all other flags 0, write_enb=0.
- Moore outputs decoded from state.
- write_enb = write_enb_reg ? (1<<addr) : 0.
- Internal full selection: full_sel = fifo_full[addr].
- DECODE_ADDRESS:
  - addr <= data_in when pkt_valid && data_in!=3.
  - If pkt_valid && data_in!=3 && fifo_empty[data_in]: -> LOAD_FIRST_DATA.
  - If pkt_valid && data_in!=3 && !fifo_empty[data_in]: -> WAIT_TILL_EMPTY.
  - data_in==3: stay, packet dropped.
- WAIT_TILL_EMPTY: busy=1; -> LOAD_FIRST_DATA when fifo_empty[addr].
- LOAD_FIRST_DATA: busy=1, lfd_state=1; -> LOAD_DATA unconditionally (1 cycle).
- LOAD_DATA: ld_state=1, write_enb_reg=1, busy=0.
  - full_sel -> FIFO_FULL_STATE (priority).
  - Else !pkt_valid -> LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE: busy=1, full_state=1, write_enb_reg=0; -> LOAD_AFTER_FULL when !full_sel.
- LOAD_AFTER_FULL: busy=1, laf_state=1, write_enb_reg=1.
  - parity_done -> DECODE_ADDRESS.
  - Else low_pkt_valid -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY: busy=1, write_enb_reg=1; -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: busy=1, rst_int_reg=1.
  - full_sel -> FIFO_FULL_STATE.
  - Else -> DECODE_ADDRESS.
- soft_reset[addr] asserted in any state other than DECODE_ADDRESS -> DECODE_ADDRESS next cycle (overrides all transitions).
- Timeout, per port i, independent of FSM:
  - cnt[i] clears when read_enb[i] or !vld_out[i].
  - Otherwise increments.
  - When cnt[i]==TIMEOUT-1 with vld_out[i] && !read_enb[i]: soft_reset[i]=1 next cycle for exactly one cycle, cnt[i] <= 0.
- Reset asserted mid-packet: all state and counters return to reset values on that edge; no write_enb on the following cycle.

Test Plan:
- Reset, then header 0x0D (len 3, port 1) with all FIFOs empty -> DECODE->LFD->LD×3->LOAD_PARITY->CHECK_PARITY_ERROR->DECODE; write_enb=3'b010 on the 5 write cycles; busy=0 only in LD.
- Header port 2 while fifo_empty[2]=0 -> WAIT_TILL_EMPTY, busy=1, no writes; drop fifo_empty[2] -> LOAD_FIRST_DATA next cycle.
- fifo_full[0] rises in LD -> FIFO_FULL_STATE, write_enb=0.
  - Release full with low_pkt_valid=1 -> LAF then LOAD_PARITY.
  - Repeat with parity_done=1 -> LAF then DECODE.
- Header data_in=3 with pkt_valid=1 -> stays DECODE_ADDRESS, write_enb=0, detect_add=1.
- fifo_empty[1]=0, read_enb[1]=0 for 30 cycles -> soft_reset[1] pulses once on cycle 31.
  - read_enb[1] at cycle 20 -> no pulse, counter restarts.
  - If port 1 active mid-packet, FSM -> DECODE_ADDRESS.
- reset=1 during LOAD_DATA -> next cycle detect_add=1, write_enb=0, soft_reset=0.

Source files
------------

// File: rtl/router_ctrl.sv
// router_ctrl: control FSM of the 1x3 router. It decodes the header address,
// sequences packet writes into three output FIFOs, and stalls when one fills.
// It also times out unread FIFOs and flushes them with a soft reset.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   pkt_valid          source byte valid (low on the parity byte)
//   data_in[1:0]       destination port in the header byte (3 = invalid)
//   parity_done        register block has captured the parity byte
//   low_pkt_valid      pkt_valid fell while loading or while full
//   fifo_full/empty    per-FIFO status flags
//   read_enb           per-port read strobe from the destination
//   write_enb          one-hot FIFO write strobe
//   vld_out            per-port data available
//   soft_reset         one-cycle per-port FIFO flush pulse
//   busy               source must hold its current byte
//   detect_add, lfd_state, ld_state, laf_state, full_state,
//   write_enb_reg, rst_int_reg   state flags for the register block

module router_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic [2:0] write_enb,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset,
    output logic       busy,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           nxt;
    logic [1:0]       addr;
    logic             hdr_ok;
    logic             full_sel;
    logic             sr_sel;
    logic             empty_hdr;
    logic             empty_sel;
    logic [CNT_W-1:0] cnt [3];

    // Address 3 never reaches the latch, but map it to 0 so the select
    // is defined for every index value.
    function automatic logic pick(input logic [2:0] v, input logic [1:0] i);
        case (i)
            2'd0:    return v[0];
            2'd1:    return v[1];
            2'd2:    return v[2];
            default: return 1'b0;
        endcase
    endfunction

    assign vld_out   = ~fifo_empty;
    assign write_enb = write_enb_reg ? (3'b001 << addr) : 3'b000;

    always_comb begin
        hdr_ok    = pkt_valid && (data_in != 2'd3);
        full_sel  = pick(fifo_full, addr);
        sr_sel    = pick(soft_reset, addr);
        empty_hdr = pick(fifo_empty, data_in);
        empty_sel = pick(fifo_empty, addr);
        nxt       = state;
        case (state)
            DECODE_ADDRESS: begin
                if (hdr_ok)
                    nxt = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_sel)
                    nxt = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (full_sel)
                    nxt = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    nxt = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!full_sel)
                    nxt = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    nxt = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    nxt = LOAD_PARITY;
                else
                    nxt = LOAD_DATA;
            end
            LOAD_PARITY: nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                nxt = full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: nxt = DECODE_ADDRESS;
        endcase
        // A flush of the FIFO being written abandons the packet.
        if (state != DECODE_ADDRESS && sr_sel)
            nxt = DECODE_ADDRESS;
    end

    // Flags are registered from the next state, so they always match
    // the state register. The header byte is written in LOAD_FIRST_DATA.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= DECODE_ADDRESS;
            addr          <= 2'd0;
            busy          <= 1'b0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            write_enb_reg <= 1'b0;
            rst_int_reg   <= 1'b0;
        end else begin
            state <= nxt;
            if (state == DECODE_ADDRESS && hdr_ok)
                addr <= data_in;
            busy          <= (nxt != DECODE_ADDRESS) && (nxt != LOAD_DATA);
            detect_add    <= (nxt == DECODE_ADDRESS);
            lfd_state     <= (nxt == LOAD_FIRST_DATA);
            ld_state      <= (nxt == LOAD_DATA);
            laf_state     <= (nxt == LOAD_AFTER_FULL);
            full_state    <= (nxt == FIFO_FULL_STATE);
            write_enb_reg <= (nxt == LOAD_FIRST_DATA) ||
                             (nxt == LOAD_DATA) ||
                             (nxt == LOAD_AFTER_FULL) ||
                             (nxt == LOAD_PARITY);
            rst_int_reg   <= (nxt == CHECK_PARITY_ERROR);
        end
    end

    // Per-port read timeout: count cycles with data pending and no read.
    always_ff @(posedge clock) begin
        if (reset) begin
            soft_reset <= 3'b000;
            for (int i = 0; i < 3; i++)
                cnt[i] <= '0;
        end else begin
            soft_reset <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (read_enb[i] || !vld_out[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    cnt[i]        <= '0;
                    soft_reset[i] <= 1'b1;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: scoreboard bench for router_ctrl. Each driven cycle
// queues the expected outputs; a negedge monitor pops and compares them.

module tb_router_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic [2:0] write_enb;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
    logic       busy;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;

    // flag byte: busy, detect_add, lfd, ld, laf, full, write_enb_reg, rst_int
    localparam logic [7:0] F_DA  = 8'b0100_0000;
    localparam logic [7:0] F_WTE = 8'b1000_0000;
    localparam logic [7:0] F_LFD = 8'b1010_0010;
    localparam logic [7:0] F_LD  = 8'b0001_0010;
    localparam logic [7:0] F_FFS = 8'b1000_0100;
    localparam logic [7:0] F_LAF = 8'b1000_1010;
    localparam logic [7:0] F_LP  = 8'b1000_0010;
    localparam logic [7:0] F_CPE = 8'b1000_0001;

    int          checks = 0;
    int          errors = 0;
    string       tq[$];
    logic [16:0] eq[$];
    string       mon_tag;
    logic [16:0] mon_exp;
    logic [16:0] obs;

    router_ctrl #(.TIMEOUT(30), .CNT_W(5)) dut (
        .clock(clock),
        .reset(reset),
        .pkt_valid(pkt_valid),
        .data_in(data_in),
        .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .read_enb(read_enb),
        .write_enb(write_enb),
        .vld_out(vld_out),
        .soft_reset(soft_reset),
        .busy(busy),
        .detect_add(detect_add),
        .lfd_state(lfd_state),
        .ld_state(ld_state),
        .laf_state(laf_state),
        .full_state(full_state),
        .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg)
    );

    always #5 clock = ~clock;

    assign obs = {vld_out, write_enb, busy, detect_add, lfd_state,
                  ld_state, laf_state, full_state, write_enb_reg,
                  rst_int_reg, soft_reset};

    task automatic chk(input string tag, input logic [16:0] got,
                       input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] ex(input logic [2:0] we,
                                       input logic [7:0] f,
                                       input logic [2:0] sr);
        return {~fifo_empty, we, f, sr};
    endfunction

    // Queue the outputs expected after the coming edge, then move on.
    task automatic step(input string tag, input logic [16:0] exp);
        tq.push_back(tag);
        eq.push_back(exp);
        @(negedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (eq.size() != 0) begin
            mon_tag = tq.pop_front();
            mon_exp = eq.pop_front();
            chk(mon_tag, obs, mon_exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        pkt_valid     = 1'b0;
        data_in       = 2'd0;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;
        fifo_full     = 3'b000;
        fifo_empty    = 3'b111;
        read_enb      = 3'b000;

        step("reset", ex(3'b000, F_DA, 3'b000));
        reset = 1'b0;

        // packet to port 1, three payload bytes
        pkt_valid = 1'b1; data_in = 2'd1;
        step("p1_hdr", ex(3'b010, F_LFD, 3'b000));
        data_in = 2'd0;
        step("p1_ld1", ex(3'b010, F_LD, 3'b000));
        step("p1_ld2", ex(3'b010, F_LD, 3'b000));
        step("p1_ld3", ex(3'b010, F_LD, 3'b000));
        pkt_valid = 1'b0;
        step("p1_par", ex(3'b010, F_LP, 3'b000));
        step("p1_cpe", ex(3'b000, F_CPE, 3'b000));
        step("p1_idle", ex(3'b000, F_DA, 3'b000));

        // port 2 busy: wait until its FIFO empties
        fifo_empty = 3'b011;
        pkt_valid = 1'b1; data_in = 2'd2;
        step("p2_wte1", ex(3'b000, F_WTE, 3'b000));
        pkt_valid = 1'b0; data_in = 2'd0;
        step("p2_wte2", ex(3'b000, F_WTE, 3'b000));
        fifo_empty = 3'b111;
        step("p2_lfd", ex(3'b100, F_LFD, 3'b000));
        step("p2_ld", ex(3'b100, F_LD, 3'b000));
        step("p2_par", ex(3'b100, F_LP, 3'b000));
        step("p2_cpe", ex(3'b000, F_CPE, 3'b000));
        step("p2_idle", ex(3'b000, F_DA, 3'b000));

        // port 0 fills, release with low_pkt_valid
        pkt_valid = 1'b1; data_in = 2'd0;
        step("f0_lfd", ex(3'b001, F_LFD, 3'b000));
        step("f0_ld", ex(3'b001, F_LD, 3'b000));
        fifo_full = 3'b001;
        step("f0_full1", ex(3'b000, F_FFS, 3'b000));
        step("f0_full2", ex(3'b000, F_FFS, 3'b000));
        fifo_full = 3'b000; low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        step("f0_laf", ex(3'b001, F_LAF, 3'b000));
        step("f0_par", ex(3'b001, F_LP, 3'b000));
        low_pkt_valid = 1'b0;
        step("f0_cpe", ex(3'b000, F_CPE, 3'b000));
        step("f0_idle", ex(3'b000, F_DA, 3'b000));

        // port 0 fills, release with parity_done
        pkt_valid = 1'b1;
        step("g0_lfd", ex(3'b001, F_LFD, 3'b000));
        step("g0_ld", ex(3'b001, F_LD, 3'b000));
        fifo_full = 3'b001;
        step("g0_full", ex(3'b000, F_FFS, 3'b000));
        fifo_full = 3'b000; parity_done = 1'b1; pkt_valid = 1'b0;
        step("g0_laf", ex(3'b001, F_LAF, 3'b000));
        step("g0_done", ex(3'b000, F_DA, 3'b000));
        parity_done = 1'b0;

        // invalid address 3 is dropped
        pkt_valid = 1'b1; data_in = 2'd3;
        step("bad1", ex(3'b000, F_DA, 3'b000));
        step("bad2", ex(3'b000, F_DA, 3'b000));
        pkt_valid = 1'b0; data_in = 2'd0;

        // port 1 unread: one flush pulse after 30 cycles
        fifo_empty = 3'b101;
        for (int k = 1; k <= 31; k++)
            step($sformatf("to_a%0d", k),
                 ex(3'b000, F_DA, (k == 30) ? 3'b010 : 3'b000));
        fifo_empty = 3'b111;
        step("to_clr1", ex(3'b000, F_DA, 3'b000));

        // a read at cycle 20 restarts the count
        fifo_empty = 3'b101;
        for (int k = 1; k <= 19; k++)
            step($sformatf("to_b%0d", k), ex(3'b000, F_DA, 3'b000));
        read_enb = 3'b010;
        step("to_rd", ex(3'b000, F_DA, 3'b000));
        read_enb = 3'b000;
        for (int k = 1; k <= 30; k++)
            step($sformatf("to_c%0d", k),
                 ex(3'b000, F_DA, (k == 30) ? 3'b010 : 3'b000));
        fifo_empty = 3'b111;
        step("to_clr2", ex(3'b000, F_DA, 3'b000));

        // timeout of the port being written aborts the packet
        pkt_valid = 1'b1; data_in = 2'd1;
        step("ab_lfd", ex(3'b010, F_LFD, 3'b000));
        fifo_empty = 3'b101;
        for (int k = 1; k <= 30; k++)
            step($sformatf("ab_ld%0d", k),
                 ex(3'b010, F_LD, (k == 30) ? 3'b010 : 3'b000));
        step("ab_abort", ex(3'b000, F_DA, 3'b000));
        pkt_valid = 1'b0; fifo_empty = 3'b111;
        step("ab_idle", ex(3'b000, F_DA, 3'b000));

        // reset in the middle of LOAD_DATA
        pkt_valid = 1'b1; data_in = 2'd0;
        step("rs_lfd", ex(3'b001, F_LFD, 3'b000));
        step("rs_ld", ex(3'b001, F_LD, 3'b000));
        reset = 1'b1;
        step("rs_hit", ex(3'b000, F_DA, 3'b000));
        reset = 1'b0; pkt_valid = 1'b0;
        step("rs_idle", ex(3'b000, F_DA, 3'b000));

        chk("sb_drain", 17'(eq.size()), 17'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
